sobel_host_ctrl: RTL and testbench
==================================

Name: sobel_host_ctrl

Overview:
Host-side initiator for sobel_top's memory/control interface.
- Accepts one frame of input pixels on a valid/ready stream and writes them into sobel_top's input memory.
- Pulses start, waits for finish, then reads the output memory and streams the result pixels out on a valid/ready stream.
- Sits between a stream source/sink (DMA or camera path) and sobel_top; it replaces the manual load/start/readback sequence.

Parameters:
- DATA_WIDTH, 8: pixel width; must equal the mem_config_pkg value.
- ADDR_WIDTH, 16: memory address width; must equal the mem_config_pkg value.
- IMG_ROWS, 64: image rows.
- IMG_COLS, 64: image columns.
- Derived: NPIX = IMG_ROWS*IMG_COLS; requires NPIX <= 2**ADDR_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- s_valid_i  in  1  input pixel valid
- s_ready_o  out  1  input pixel accepted when valid&ready
- s_data_i  in  DATA_WIDTH  input pixel
- s_last_i  in  1  marks final pixel of frame
- m_valid_o  out  1  output pixel valid
- m_ready_i  in  1  sink ready
- m_data_o  out  DATA_WIDTH  output pixel
- m_last_o  out  1  high on output pixel NPIX-1
- start_o  out  1  to sobel_top start_i
- finish_i  in  1  from sobel_top finish_o
- wr_en_imem_o  out  1  input memory write enable
- addr_imem_o  out  ADDR_WIDTH  input memory address
- data_imem_o  out  DATA_WIDTH  input memory write data
- rd_en_omem_o  out  1  output memory read enable
- addr_omem_o  out  ADDR_WIDTH  output memory address
- data_omem_i  in  DATA_WIDTH  output memory read data, valid 1 cycle after rd_en_omem_o
- busy_o  out  1  high in any state other than IDLE
- frame_done_o  out  1  1-cycle pulse when the last output pixel is accepted
- len_err_o  out  1  1-cycle pulse on frame-length mismatch

Behaviour:
Reset:
- rst_i high at a clock edge puts the FSM in IDLE and clears all counters and the output buffer.
- Every output is 0 during and after reset, except s_ready_o, which is 1 once in IDLE.
- Reset mid-frame abandons the frame; no partial stream is resumed.

FSM states: IDLE, LOAD, START, RUN, DRAIN.
- IDLE: s_ready_o=1. An accepted pixel writes address 0 and moves to LOAD with wcnt=1.
- LOAD: s_ready_o=1.
  - Each accepted pixel drives wr_en_imem_o=1, addr_imem_o=wcnt, data_imem_o=s_data_i in the same cycle (combinational pass-through, registered address counter); wcnt then increments.
  - On the accept with wcnt==NPIX-1: go to START.
  - If s_last_i is high on an earlier accept: pulse len_err_o, still write that pixel, and go to START. Remaining addresses keep stale data.
  - If s_last_i is low on pixel NPIX-1: pulse len_err_o and proceed anyway.
- START: s_ready_o=0, start_o=1 for exactly one cycle, then RUN.
- RUN: wait for a rising edge of finish_i (finish_i & ~finish_q, with finish_q registered). A finish_i already high on entry is ignored until it falls and rises again. On the edge go to DRAIN with rcnt=0.
- DRAIN:
  - Read issue: issue rd_en_omem_o=1, addr_omem_o=rcnt when rcnt<NPIX and (buffer occupancy + reads in flight) < 2; rcnt then increments.
  - Capture: data_omem_i is captured into a 2-entry FIFO the cycle after the issue.
  - Output: m_valid_o = FIFO not empty; m_data_o = FIFO head; m_last_o is high on the head for index NPIX-1.
  - Sustained throughput is 1 pixel/cycle with m_ready_i held high.
  - When the NPIX-1 pixel is accepted: pulse frame_done_o and return to IDLE.
- Stream rules: m_valid_o and m_data_o stay stable while m_valid_o & ~m_ready_i. rd_en_omem_o is 0 outside DRAIN. wr_en_imem_o is 0 outside IDLE/LOAD accepts.
- Addresses are zero-extended counters. No wrap occurs because NPIX <= 2**ADDR_WIDTH. Counters are ADDR_WIDTH+1 bits so NPIX itself is representable.

Decomposition:
- Put in sobel_config_pkg: the state enum typedef (host_state_e) and NPIX as a localparam derived from IMAGE_ROW_SIZE/IMAGE_COLUMN_SIZE.
- Put in mem_config_pkg: DATA_WIDTH and ADDR_WIDTH.
- One sub-module: sobel_rd_skid_fifo, a 2-entry FIFO with valid/ready output and a count output used for read credit.

Test Plan (IMG_ROWS=IMG_COLS=4, NPIX=16, 1-cycle-latency memory model, sobel_top stub asserting finish 20 cycles after start):
- Load 16 pixels 0x00..0x0F back-to-back, s_last_i on the 16th -> wr_en_imem_o on 16 consecutive cycles, addresses 0..15; start_o high for exactly 1 cycle the next cycle; len_err_o never pulses.
- After finish, m_ready_i held high, omem[i]=0xF0+i -> m_data_o 0xF0..0xFF on 16 consecutive valid cycles; m_last_o only on 0xFF; frame_done_o pulses once; busy_o falls the following cycle.
- Random m_ready_i backpressure (~50%) -> output sequence unchanged and in order; no rd_en_omem_o issue while occupancy+inflight==2; m_data_o stable while stalled.
- s_last_i asserted on the 10th pixel -> len_err_o pulses on that accept; start_o follows the next cycle; 16 pixels still read back.
- finish_i held high before start, low for 3 cycles, then high -> DRAIN entered only on the later rising edge.
- rst_i asserted mid-DRAIN at pixel 7 -> next cycle all outputs 0 and s_ready_o=1; a new frame then loads from address 0.

Source files
------------

// File: rtl/mem_config_pkg.sv
// Memory interface widths shared by sobel_top and its host-side controller.
package mem_config_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 16;

endpackage

// File: rtl/sobel_config_pkg.sv
// Image geometry and host controller state encoding for the sobel block.
package sobel_config_pkg;

    localparam int IMAGE_ROW_SIZE    = 64;
    localparam int IMAGE_COLUMN_SIZE = 64;
    localparam int NPIX              = IMAGE_ROW_SIZE * IMAGE_COLUMN_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DRAIN
    } host_state_e;

endpackage

// File: rtl/sobel_rd_skid_fifo.sv
// Two-entry FIFO capturing output-memory read data; count feeds the read credit.
module sobel_rd_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rptr;
    logic             wptr;
    logic             pop;

    assign valid = (count != 2'd0);
    assign pop   = valid & ready;
    assign data  = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sobel_host_ctrl.sv
// Host-side initiator: loads a frame into sobel_top, starts it, waits for
// finish and streams the result memory back out.
module sobel_host_ctrl
    import sobel_config_pkg::*;
#(
    parameter int DATA_WIDTH = mem_config_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_config_pkg::ADDR_WIDTH,
    parameter int IMG_ROWS   = IMAGE_ROW_SIZE,
    parameter int IMG_COLS   = IMAGE_COLUMN_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  start_o,
    input  logic                  finish_i,
    output logic                  wr_en_imem_o,
    output logic [ADDR_WIDTH-1:0] addr_imem_o,
    output logic [DATA_WIDTH-1:0] data_imem_o,
    output logic                  rd_en_omem_o,
    output logic [ADDR_WIDTH-1:0] addr_omem_o,
    input  logic [DATA_WIDTH-1:0] data_omem_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  len_err_o
);

    localparam int              NUM_PIX  = IMG_ROWS * IMG_COLS;
    localparam int              CW       = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_PIX - 1);
    localparam logic [CW-1:0]   PIX_CNT  = CW'(NUM_PIX);

    if (NUM_PIX > (1 << ADDR_WIDTH)) begin : g_bad_size
        $error("sobel_host_ctrl: image does not fit the address space");
    end

    host_state_e           state, state_n;
    logic [CW-1:0]         wcnt, wcnt_n;
    logic [CW-1:0]         rcnt, rcnt_n;
    logic [CW-1:0]         ocnt, ocnt_n;
    logic [CW-1:0]         wr_idx;
    logic                  finish_q;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            occ;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [1:0]            fifo_count;

    sobel_rd_skid_fifo #(
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (inflight),
        .push_data(data_omem_i),
        .ready    (pop),
        .valid    (fifo_valid),
        .data     (fifo_data),
        .count    (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            rcnt     <= '0;
            ocnt     <= '0;
            finish_q <= 1'b0;
            inflight <= 1'b0;
        end else begin
            state    <= state_n;
            wcnt     <= wcnt_n;
            rcnt     <= rcnt_n;
            ocnt     <= ocnt_n;
            finish_q <= finish_i;
            inflight <= rd_en_omem_o;
        end
    end

    assign busy_o = (state != S_IDLE);

    always_comb begin
        state_n      = state;
        wcnt_n       = wcnt;
        rcnt_n       = rcnt;
        ocnt_n       = ocnt;
        s_ready_o    = 1'b0;
        wr_en_imem_o = 1'b0;
        addr_imem_o  = '0;
        data_imem_o  = '0;
        start_o      = 1'b0;
        len_err_o    = 1'b0;
        m_valid_o    = 1'b0;
        m_data_o     = '0;
        m_last_o     = 1'b0;
        rd_en_omem_o = 1'b0;
        addr_omem_o  = '0;
        frame_done_o = 1'b0;
        pop          = 1'b0;
        occ          = '0;
        wr_idx       = (state == S_LOAD) ? wcnt : '0;

        unique case (state)
            S_IDLE, S_LOAD: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    wr_en_imem_o = 1'b1;
                    addr_imem_o  = wr_idx[ADDR_WIDTH-1:0];
                    data_imem_o  = s_data_i;
                    wcnt_n       = wr_idx + CW'(1);
                    if (wr_idx == LAST_IDX) begin
                        state_n   = S_START;
                        len_err_o = ~s_last_i;
                    end else if (s_last_i) begin
                        state_n   = S_START;
                        len_err_o = 1'b1;
                    end else begin
                        state_n = S_LOAD;
                    end
                end
            end
            S_START: begin
                start_o = 1'b1;
                state_n = S_RUN;
            end
            S_RUN: begin
                if (finish_i && !finish_q) begin
                    state_n = S_DRAIN;
                    rcnt_n  = '0;
                    ocnt_n  = '0;
                end
            end
            S_DRAIN: begin
                m_valid_o = fifo_valid;
                m_data_o  = fifo_valid ? fifo_data : '0;
                m_last_o  = fifo_valid && (ocnt == LAST_IDX);
                pop       = fifo_valid && m_ready_i;
                // Credit counts the slot freed by this cycle's pop so a
                // continuously-ready sink sees one pixel per cycle.
                occ = fifo_count + {1'b0, inflight} - {1'b0, pop};
                if ((rcnt < PIX_CNT) && (occ < 2'd2)) begin
                    rd_en_omem_o = 1'b1;
                    addr_omem_o  = rcnt[ADDR_WIDTH-1:0];
                    rcnt_n       = rcnt + CW'(1);
                end
                if (pop) begin
                    ocnt_n = ocnt + CW'(1);
                    if (ocnt == LAST_IDX) begin
                        frame_done_o = 1'b1;
                        state_n      = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sobel_host_ctrl.sv
// Scoreboard bench for sobel_host_ctrl on a 4x4 image with a stub sobel_top.
module tb_sobel_host_ctrl;

    localparam int NP = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        s_valid_i, s_ready_o, s_last_i;
    logic [7:0]  s_data_i;
    logic        m_valid_o, m_ready_i, m_last_o;
    logic [7:0]  m_data_o;
    logic        start_o, finish_i;
    logic        wr_en_imem_o, rd_en_omem_o;
    logic [15:0] addr_imem_o, addr_omem_o;
    logic [7:0]  data_imem_o, data_omem_i;
    logic        busy_o, frame_done_o, len_err_o;

    sobel_host_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(16),
        .IMG_ROWS  (4),
        .IMG_COLS  (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .s_last_i    (s_last_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o),
        .start_o     (start_o),
        .finish_i    (finish_i),
        .wr_en_imem_o(wr_en_imem_o),
        .addr_imem_o (addr_imem_o),
        .data_imem_o (data_imem_o),
        .rd_en_omem_o(rd_en_omem_o),
        .addr_omem_o (addr_omem_o),
        .data_omem_i (data_omem_i),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .len_err_o   (len_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output memory and sobel_top stub
    logic [7:0] omem [NP];
    logic       finish_auto = 1'b0;
    logic       finish_man  = 1'b0;
    logic       man_mode    = 1'b0;
    int         fcnt        = 0;
    assign finish_i = man_mode ? finish_man : finish_auto;

    always @(posedge clk) begin
        if (rd_en_omem_o) data_omem_i <= omem[addr_omem_o[3:0]];
        if (start_o) begin
            fcnt        <= 20;
            finish_auto <= 1'b0;
        end else if (fcnt != 0) begin
            fcnt <= fcnt - 1;
            if (fcnt == 1) finish_auto <= 1'b1;
        end
    end

    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        m_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboards: write queue {addr,data}, output queue {last,data}
    logic [23:0] wq [$];
    logic [8:0]  oq [$];

    int wr_cnt, wr_first, wr_last, out_cnt, out_first, out_last;
    int start_cnt, start_cyc, len_cnt, len_cyc, done_cnt, rd_cnt, rd_first;
    int pending = 0;
    int rd_idx  = 0;
    bit prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        popn;
    logic [23:0] we;
    logic [8:0]  oe;

    always @(negedge clk) begin
        if (rst_i) begin
            pending    = 0;
            prev_stall = 1'b0;
            rd_idx     = 0;
        end else begin
            popn = m_valid_o && m_ready_i;
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid_o), 1);
                check("stall_data", 32'(m_data_o), 32'(prev_data));
            end
            if (wr_en_imem_o) begin
                check("wr_expected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    we = wq.pop_front();
                    check("wr_addr", 32'(addr_imem_o), 32'(we[23:8]));
                    check("wr_data", 32'(data_imem_o), 32'(we[7:0]));
                end
                if (wr_cnt == 0) wr_first = cyc;
                wr_last = cyc;
                wr_cnt++;
            end
            if (popn) begin
                check("out_expected", 32'(oq.size() != 0), 1);
                if (oq.size() != 0) begin
                    oe = oq.pop_front();
                    check("out_data", 32'(m_data_o), 32'(oe[7:0]));
                    check("out_last", 32'(m_last_o), 32'(oe[8]));
                end
                if (out_cnt == 0) out_first = cyc;
                out_last = cyc;
                out_cnt++;
            end
            if (rd_en_omem_o) begin
                check("rd_addr", 32'(addr_omem_o), 32'(rd_idx));
                check("rd_credit", 32'((pending - int'(popn)) < 2), 1);
                if (rd_cnt == 0) rd_first = cyc;
                rd_cnt++;
                rd_idx++;
            end
            pending = pending + int'(rd_en_omem_o) - int'(popn);
            if (start_o) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (len_err_o) begin
                check("len_err_on_accept", 32'(wr_en_imem_o), 1);
                len_cnt++;
                len_cyc = cyc;
            end
            if (frame_done_o) begin
                check("done_on_last", 32'(popn && m_last_o), 1);
                done_cnt++;
                rd_idx = 0;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
        end
    end

    task automatic clr_stats();
        wr_cnt = 0; out_cnt = 0; start_cnt = 0; len_cnt = 0; done_cnt = 0; rd_cnt = 0;
        wr_first = -1; wr_last = -1; out_first = -1; out_last = -1;
        start_cyc = -1; len_cyc = -1; rd_first = -1;
    endtask

    task automatic check_idle();
        check("idle_s_ready", 32'(s_ready_o), 1);
        check("idle_busy", 32'(busy_o), 0);
        check("idle_m_valid", 32'(m_valid_o), 0);
        check("idle_m_data", 32'(m_data_o), 0);
        check("idle_m_last", 32'(m_last_o), 0);
        check("idle_start", 32'(start_o), 0);
        check("idle_wr_en", 32'(wr_en_imem_o), 0);
        check("idle_addr_imem", 32'(addr_imem_o), 0);
        check("idle_data_imem", 32'(data_imem_o), 0);
        check("idle_rd_en", 32'(rd_en_omem_o), 0);
        check("idle_addr_omem", 32'(addr_omem_o), 0);
        check("idle_frame_done", 32'(frame_done_o), 0);
        check("idle_len_err", 32'(len_err_o), 0);
    endtask

    // Caller is at posedge+1; returns at posedge+1.
    task automatic prep_frame(input logic [7:0] base);
        clr_stats();
        for (int i = 0; i < NP; i++) begin
            omem[i] = base + 8'(i);
            oq.push_back({i == NP - 1, base + 8'(i)});
        end
    endtask

    task automatic send_frame(input int n, input int last_at, input logic [7:0] dbase);
        bit acc;
        int t;
        for (int i = 0; i < n; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = dbase + 8'(i);
            s_last_i  = (i == last_at);
            wq.push_back({16'(i), dbase + 8'(i)});
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 50) begin
                @(negedge clk);
                acc = s_ready_o;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) check("s_ready_timeout", 32'(s_ready_o), 1);
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic wait_done();
        bit found = 1'b0;
        for (int t = 0; t < 2000 && !found; t++) begin
            @(negedge clk);
            found = frame_done_o;
        end
        if (!found) check("done_timeout", 32'(frame_done_o), 1);
        @(negedge clk);
        check("busy_fall", 32'(busy_o), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input int n_wr, input int exp_len, input bit tight);
        check("wq_empty", 32'(wq.size()), 0);
        check("oq_empty", 32'(oq.size()), 0);
        check("wr_count", 32'(wr_cnt), 32'(n_wr));
        check("out_count", 32'(out_cnt), NP);
        check("rd_count", 32'(rd_cnt), NP);
        check("start_count", 32'(start_cnt), 1);
        check("start_timing", 32'(start_cyc), 32'(wr_last + 1));
        check("done_count", 32'(done_cnt), 1);
        check("len_err_count", 32'(len_cnt), 32'(exp_len));
        if (exp_len != 0) check("len_err_timing", 32'(len_cyc), 32'(wr_last));
        if (tight) begin
            check("wr_back_to_back", 32'(wr_last - wr_first), NP - 1);
            check("out_back_to_back", 32'(out_last - out_first), NP - 1);
        end
    endtask

    task automatic run_frame(input int n, input int last_at, input logic [7:0] base,
                             input logic [7:0] dbase, input bit rnd, input int exp_len,
                             input bit tight);
        prep_frame(base);
        rand_rdy = rnd;
        send_frame(n, last_at, dbase);
        wait_done();
        rand_rdy = 1'b0;
        end_checks(n, exp_len, tight);
    endtask

    initial begin
        int rise_cyc;
        bit hit;
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        s_data_i  = '0;
        clr_stats();
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_idle();
        @(posedge clk);
        #1;

        // Nominal frame, sink always ready
        run_frame(NP, NP - 1, 8'hF0, 8'h00, 1'b0, 0, 1'b1);
        // Random backpressure
        run_frame(NP, NP - 1, 8'h30, 8'h80, 1'b1, 0, 1'b0);
        // Early s_last on the 10th pixel
        run_frame(10, 9, 8'h60, 8'h20, 1'b0, 1, 1'b0);

        // finish already high before start: only a later rising edge counts
        man_mode   = 1'b1;
        finish_man = 1'b1;
        prep_frame(8'hC0);
        send_frame(NP, NP - 1, 8'h40);
        repeat (10) @(posedge clk);
        #1;
        check("held_finish_no_read", 32'(rd_cnt), 0);
        check("held_finish_busy", 32'(busy_o), 1);
        finish_man = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("low_finish_no_read", 32'(rd_cnt), 0);
        finish_man = 1'b1;
        rise_cyc   = cyc;
        wait_done();
        end_checks(NP, 0, 1'b0);
        check("drain_after_rise", 32'(rd_first), 32'(rise_cyc + 1));
        man_mode = 1'b0;

        // Reset mid-drain after pixel 7 is accepted
        prep_frame(8'hA0);
        send_frame(NP, NP - 1, 8'h10);
        hit = 1'b0;
        for (int t = 0; t < 500 && !hit; t++) begin
            @(negedge clk);
            hit = m_valid_o && m_ready_i && (m_data_o == 8'hA7);
        end
        check("reached_pixel7", 32'(hit), 1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        oq.delete();
        wq.delete();
        @(negedge clk);
        check_idle();
        @(posedge clk);
        #1;
        // New frame from address 0, s_last never asserted
        run_frame(NP, -1, 8'h50, 8'hE0, 1'b0, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
